// File: rtl/idma_legalizer_burst_axi.sv
// idma_legalizer_burst_axi
// Splits 1D copy requests (src, dst, length) into legal AXI4 read and write
// bursts. Each burst respects the 4 KiB page rule, the configured maximum burst
// length, and the 16-beat FIXED limit. Read and write sides can emit bursts in
// lock-step (coupled) or independently (decoupled).
//
// Optional build macro IDMA_LEGALIZER_STATS_EN adds r_burst_cnt_o/w_burst_cnt_o.
// These count accepted bursts per side and are cleared only by reset.
module idma_legalizer_burst_axi #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned MaxBeats  = 256,
  localparam int unsigned StrbWidth   = DataWidth / 8,
  localparam int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_src_addr_i,
  input  logic [AddrWidth-1:0]   req_dst_addr_i,
  input  logic [LenWidth-1:0]    req_length_i,
  input  logic                   req_decouple_i,
  input  logic                   req_src_fixed_i,
  input  logic                   req_dst_fixed_i,
  input  logic                   kill_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [AddrWidth-1:0]   r_addr_o,
  output logic [7:0]             r_len_o,
  output logic                   r_fixed_o,
  output logic [OffsetWidth-1:0] r_offset_o,
  output logic [OffsetWidth-1:0] r_tailer_o,
  output logic                   r_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [AddrWidth-1:0]   w_addr_o,
  output logic [7:0]             w_len_o,
  output logic                   w_fixed_o,
  output logic [OffsetWidth-1:0] w_offset_o,
  output logic [OffsetWidth-1:0] w_tailer_o,
  output logic                   w_last_o,
  output logic                   r_busy_o,
  output logic                   w_busy_o
`ifdef IDMA_LEGALIZER_STATS_EN
  ,
  output logic [31:0]            r_burst_cnt_o,
  output logic [31:0]            w_burst_cnt_o
`endif
);

  // An INCR burst may not cross this boundary. It is either the 4 KiB page or
  // the longest burst in bytes, whichever is smaller.
  localparam int unsigned MaxBurstBytes = MaxBeats * StrbWidth;
  localparam int unsigned Boundary      = (MaxBurstBytes < 4096) ? MaxBurstBytes : 4096;
  localparam int unsigned BoundW        = $clog2(Boundary);
  localparam int unsigned FixedBeats    = (MaxBeats < 16) ? MaxBeats : 16;
  localparam int unsigned FixedBytes    = FixedBeats * StrbWidth;

  // Bytes a side may move in one burst from its current address.
  function automatic logic [LenWidth-1:0] cap_bytes(input logic [AddrWidth-1:0] addr,
                                                    input logic                 fixed);
    logic [LenWidth-1:0] cap;
    if (fixed) cap = LenWidth'(FixedBytes);
    else       cap = LenWidth'(Boundary) - LenWidth'(addr[BoundW-1:0]);
    return cap;
  endfunction

  function automatic logic [LenWidth-1:0] min_len(input logic [LenWidth-1:0] a,
                                                  input logic [LenWidth-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // AXI len field: number of data beats touched minus one.
  function automatic logic [7:0] beats_m1(input logic [LenWidth-1:0]    chunk,
                                          input logic [OffsetWidth-1:0] offset);
    logic [LenWidth-1:0] span;
    span = chunk + LenWidth'(offset) - LenWidth'(1);
    return 8'(span >> OffsetWidth);
  endfunction

  // Byte lane just past the last valid byte, modulo the bus width.
  function automatic logic [OffsetWidth-1:0] tailer(input logic [LenWidth-1:0]    chunk,
                                                    input logic [OffsetWidth-1:0] offset);
    logic [LenWidth-1:0] end_pos;
    end_pos = chunk + LenWidth'(offset);
    return end_pos[OffsetWidth-1:0];
  endfunction

  // Control state.
  logic r_busy, w_busy, decouple;
  // Data state. It is only meaningful while the matching busy flag is set.
  logic [AddrWidth-1:0] r_addr, w_addr;
  logic [LenWidth-1:0]  r_rem, w_rem;
  logic                 r_fixed, w_fixed;

  logic [LenWidth-1:0]    r_cap, w_cap, r_chunk, w_chunk;
  logic [OffsetWidth-1:0] r_off, w_off;
  logic                   r_last, w_last, r_fire, w_fire, r_done, w_done, accept;

  // Burst sizing. In coupled mode both sides take the smallest cap, so the read
  // and write bursts always cover the same bytes.
  always_comb begin
    r_cap   = cap_bytes(r_addr, r_fixed);
    w_cap   = cap_bytes(w_addr, w_fixed);
    r_chunk = min_len(r_rem, min_len(r_cap, w_cap));
    w_chunk = r_chunk;
    if (decouple) begin
      r_chunk = min_len(r_rem, r_cap);
      w_chunk = min_len(w_rem, w_cap);
    end
  end

  assign r_off  = r_addr[OffsetWidth-1:0];
  assign w_off  = w_addr[OffsetWidth-1:0];
  assign r_last = (r_chunk == r_rem);
  assign w_last = (w_chunk == w_rem);

  // In coupled mode each side shows valid only when the other side can take
  // its burst in the same cycle. Then both handshakes always fire together.
  assign r_valid_o = r_busy & (decouple | w_ready_i);
  assign w_valid_o = w_busy & (decouple | r_ready_i);
  assign r_fire    = r_valid_o & r_ready_i;
  assign w_fire    = w_valid_o & w_ready_i;

  // A side can take a new request if it is idle, or if it is handing off its
  // final burst this cycle. This gives back-to-back requests with no bubble.
  assign r_done      = ~r_busy | (r_fire & r_last);
  assign w_done      = ~w_busy | (w_fire & w_last);
  assign req_ready_o = r_done & w_done & ~kill_i;
  assign accept      = req_valid_i & req_ready_o;

  assign r_addr_o   = r_busy ? {r_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign r_len_o    = r_busy ? beats_m1(r_chunk, r_off) : '0;
  assign r_fixed_o  = r_busy & r_fixed;
  assign r_offset_o = r_busy ? r_off : '0;
  assign r_tailer_o = r_busy ? tailer(r_chunk, r_off) : '0;
  assign r_last_o   = r_busy & r_last;

  assign w_addr_o   = w_busy ? {w_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign w_len_o    = w_busy ? beats_m1(w_chunk, w_off) : '0;
  assign w_fixed_o  = w_busy & w_fixed;
  assign w_offset_o = w_busy ? w_off : '0;
  assign w_tailer_o = w_busy ? tailer(w_chunk, w_off) : '0;
  assign w_last_o   = w_busy & w_last;

  assign r_busy_o = r_busy;
  assign w_busy_o = w_busy;

  // Busy/mode control: reset and kill drop the transfer; accept loads a new one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_busy   <= 1'b0;
      w_busy   <= 1'b0;
      decouple <= 1'b0;
    end else if (kill_i) begin
      r_busy <= 1'b0;
      w_busy <= 1'b0;
    end else if (accept) begin
      r_busy   <= (req_length_i != '0);
      w_busy   <= (req_length_i != '0);
      decouple <= req_decouple_i;
    end else begin
      if (r_fire && r_last) r_busy <= 1'b0;
      if (w_fire && w_last) w_busy <= 1'b0;
    end
  end

  // Address/remaining bookkeeping. FIXED sides keep hitting the same address.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      r_addr  <= req_src_addr_i;
      r_rem   <= req_length_i;
      r_fixed <= req_src_fixed_i;
      w_addr  <= req_dst_addr_i;
      w_rem   <= req_length_i;
      w_fixed <= req_dst_fixed_i;
    end else begin
      if (r_fire) begin
        r_rem <= r_rem - r_chunk;
        if (!r_fixed) r_addr <= r_addr + AddrWidth'(r_chunk);
      end
      if (w_fire) begin
        w_rem <= w_rem - w_chunk;
        if (!w_fixed) w_addr <= w_addr + AddrWidth'(w_chunk);
      end
    end
  end

`ifdef IDMA_LEGALIZER_STATS_EN
  logic [31:0] r_cnt, w_cnt;

  // Accepted-burst counters per side. They wrap naturally, and kill leaves them alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      w_cnt <= '0;
    end else begin
      if (r_fire) r_cnt <= r_cnt + 32'd1;
      if (w_fire) w_cnt <= w_cnt + 32'd1;
    end
  end

  assign r_burst_cnt_o = r_cnt;
  assign w_burst_cnt_o = w_cnt;
`endif

endmodule
